// File: rtl/bcd_pkg.sv
// Shared BCD definitions for the counter slice.
//   BcdW      : bits per BCD digit
//   BcdMax    : largest legal digit value
//   BcdWideW  : width of a packed BCD word wide enough for any legal modulus (9 digits)
//   int_to_bcd: constant-foldable integer -> packed BCD conversion
//   pow10     : 10^n, used to bound the modulus against the digit count
package bcd_pkg;

  localparam int unsigned BcdW     = 4;
  localparam logic [3:0]  BcdMax   = 4'd9;
  localparam int unsigned BcdWideW = BcdW * 9;

  typedef logic [BcdWideW-1:0] bcd_wide_t;

  function automatic bcd_wide_t int_to_bcd(input longint unsigned val);
    bcd_wide_t       r;
    longint unsigned v;
    r = '0;
    v = val;
    for (int i = 0; i < 9; i++) begin
      r[BcdW*i +: BcdW] = 4'(v % 64'd10);
      v = v / 64'd10;
    end
    return r;
  endfunction

  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit stepped up or down by a carry/borrow input. Purely combinational.
//   digit_in  : current digit (0..9)
//   up_dn     : 1 = increment, 0 = decrement
//   cin       : apply the step (carry in when counting up, borrow in when counting down)
//   digit_out : stepped digit
//   cout      : carry out (9 -> 0) or borrow out (0 -> 9)
module bcd_digit
  import bcd_pkg::*;
(
  input  logic [3:0] digit_in,
  input  logic       up_dn,
  input  logic       cin,
  output logic [3:0] digit_out,
  output logic       cout
);

  always_comb begin
    digit_out = digit_in;
    cout      = 1'b0;
    if (cin) begin
      if (up_dn) begin
        // >= keeps an out-of-range digit from ever escaping 0..9
        if (digit_in >= BcdMax) begin
          digit_out = 4'd0;
          cout      = 1'b1;
        end else begin
          digit_out = digit_in + 4'd1;
        end
      end else begin
        if (digit_in == 4'd0) begin
          digit_out = BcdMax;
          cout      = 1'b1;
        end else begin
          digit_out = digit_in - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/bcd_counter_n.sv
// Multi-digit BCD up/down counter with programmable modulus and validated load.
//   clk      : clock, all state changes on the rising edge
//   preset   : asynchronous active-high reset, forces q to RESET_VAL
//   en       : count enable
//   up_dn    : direction, 1 = up, 0 = down
//   load     : synchronous load strobe (priority over en)
//   load_val : packed BCD load value, digit 0 in [3:0]
//   q        : packed BCD count, digit 0 in [3:0]
//   carry    : one-cycle pulse in the cycle q shows a wrapped value
//   load_err : one-cycle pulse after a rejected load
module bcd_counter_n
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS    = 2,
  parameter int unsigned MODULUS   = 60,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic                   clk,
  input  logic                   preset,
  input  logic                   en,
  input  logic                   up_dn,
  input  logic                   load,
  input  logic [BcdW*DIGITS-1:0] load_val,
  output logic [BcdW*DIGITS-1:0] q,
  output logic                   carry,
  output logic                   load_err
);

  localparam int unsigned     W         = BcdW * DIGITS;
  localparam longint unsigned ModSpan   = pow10(DIGITS);
  localparam bit              FullRange = (64'(MODULUS) == ModSpan);
  localparam bcd_wide_t       ModBcd    = int_to_bcd(64'(MODULUS));
  localparam bcd_wide_t       TopBcd    = int_to_bcd(64'(MODULUS) - 64'd1);
  localparam bcd_wide_t       ResetBcd  = int_to_bcd(64'(RESET_VAL));

  if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
    $error("bcd_counter_n: DIGITS must be 1..8");
  end
  if (MODULUS < 2 || 64'(MODULUS) > ModSpan) begin : g_bad_modulus
    $error("bcd_counter_n: MODULUS must be 2..10**DIGITS");
  end
  if (RESET_VAL >= MODULUS) begin : g_bad_reset_val
    $error("bcd_counter_n: RESET_VAL must be below MODULUS");
  end

  logic [W-1:0]    q_q, q_d, stepped;
  logic            carry_q, carry_d;
  logic            load_err_q, load_err_d;
  logic [DIGITS:0] chain;
  logic            digits_ok, below_mod, load_ok;
  logic            wrap_up, wrap_dn;

  // Ripple carry/borrow through the digits; digit 0 always steps.
  assign chain[0] = 1'b1;
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .digit_in  (q_q[BcdW*i +: BcdW]),
      .up_dn     (up_dn),
      .cin       (chain[i]),
      .digit_out (stepped[BcdW*i +: BcdW]),
      .cout      (chain[i+1])
    );
  end

  // Borrow out of the top digit happens exactly when every digit is 0.
  assign wrap_dn = ~up_dn & chain[DIGITS];
  // A full-range counter wraps on its natural carry out; otherwise match MODULUS-1 digit-wise.
  assign wrap_up = up_dn & (FullRange ? chain[DIGITS] : (q_q == TopBcd[W-1:0]));

  always_comb begin
    digits_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_val[BcdW*i +: BcdW] > BcdMax) begin
        digits_ok = 1'b0;
      end
    end
  end

  // With every digit valid, comparing packed BCD words MSD-first is a decimal compare.
  assign below_mod = ({{(BcdWideW-W){1'b0}}, load_val} < ModBcd);
  assign load_ok   = digits_ok & below_mod;

  always_comb begin
    q_d        = q_q;
    carry_d    = 1'b0;
    load_err_d = 1'b0;
    if (load) begin
      if (load_ok) begin
        q_d = load_val;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (en) begin
      if (wrap_up) begin
        q_d     = '0;
        carry_d = 1'b1;
      end else if (wrap_dn) begin
        q_d     = TopBcd[W-1:0];
        carry_d = 1'b1;
      end else begin
        q_d = stepped;
      end
    end
  end

  always_ff @(posedge clk or posedge preset) begin
    if (preset) begin
      q_q        <= ResetBcd[W-1:0];
      carry_q    <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      q_q        <= q_d;
      carry_q    <= carry_d;
      load_err_q <= load_err_d;
    end
  end

  assign q        = q_q;
  assign carry    = carry_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_counter_n.sv
// Self-checking bench: three counter configurations (60/2 digits, 1000/3 digits, 24/2 digits),
// an integer reference model feeding a scoreboard queue of expected outputs.
module tb_bcd_counter_n;

  typedef struct {
    int          d;
    logic [11:0] q;
    logic        c;
    logic        e;
    string       tag;
  } exp_t;

  logic        clk;
  logic [2:0]  preset, en, up_dn, load;
  logic [7:0]  lv0, lv2;
  logic [11:0] lv1;
  logic [7:0]  q0, q2;
  logic [11:0] q1;
  logic [2:0]  carry, lerr;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   mv[3]     = '{12, 0, 5};
  int   mods[3]   = '{60, 1000, 24};
  int   digits[3] = '{2, 3, 2};

  bcd_counter_n #(.DIGITS(2), .MODULUS(60), .RESET_VAL(12)) u_dut0 (
    .clk(clk), .preset(preset[0]), .en(en[0]), .up_dn(up_dn[0]), .load(load[0]),
    .load_val(lv0), .q(q0), .carry(carry[0]), .load_err(lerr[0])
  );
  bcd_counter_n #(.DIGITS(3), .MODULUS(1000), .RESET_VAL(0)) u_dut1 (
    .clk(clk), .preset(preset[1]), .en(en[1]), .up_dn(up_dn[1]), .load(load[1]),
    .load_val(lv1), .q(q1), .carry(carry[1]), .load_err(lerr[1])
  );
  bcd_counter_n #(.DIGITS(2), .MODULUS(24), .RESET_VAL(5)) u_dut2 (
    .clk(clk), .preset(preset[2]), .en(en[2]), .up_dn(up_dn[2]), .load(load[2]),
    .load_val(lv2), .q(q2), .carry(carry[2]), .load_err(lerr[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] r;
    int          t;
    r = '0;
    t = v;
    for (int i = 0; i < 3; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [11:0] cur_q(input int d);
    case (d)
      0:       return {4'h0, q0};
      1:       return q1;
      default: return {4'h0, q2};
    endcase
  endfunction

  task automatic push_exp(input int d, input logic c, input logic e, input string tag);
    exp_t x;
    x.d   = d;
    x.q   = to_bcd(mv[d]);
    x.c   = c;
    x.e   = e;
    x.tag = tag;
    sb.push_back(x);
  endtask

  task automatic check_front();
    exp_t        x;
    logic [11:0] oq;
    x  = sb.pop_front();
    oq = cur_q(x.d);
    checks++;
    assert (oq === x.q) else begin
      errors++;
      $error("FAIL %s q: observed %h expected %h", x.tag, oq, x.q);
    end
    checks++;
    assert (carry[x.d] === x.c) else begin
      errors++;
      $error("FAIL %s carry: observed %b expected %b", x.tag, carry[x.d], x.c);
    end
    checks++;
    assert (lerr[x.d] === x.e) else begin
      errors++;
      $error("FAIL %s load_err: observed %b expected %b", x.tag, lerr[x.d], x.e);
    end
  endtask

  // Drive one cycle of stimulus on DUT d, model it, then compare after the edge.
  task automatic step(input int d, input logic l, input logic e, input logic u,
                      input logic [11:0] val, input string tag);
    logic c, err, ok;
    int   dv;
    load[d]  = l;
    en[d]    = e;
    up_dn[d] = u;
    case (d)
      0:       lv0 = val[7:0];
      1:       lv1 = val;
      default: lv2 = val[7:0];
    endcase
    c   = 1'b0;
    err = 1'b0;
    if (l) begin
      ok = 1'b1;
      dv = 0;
      for (int i = digits[d] - 1; i >= 0; i--) begin
        if (val[4*i +: 4] > 4'd9) ok = 1'b0;
        dv = dv * 10 + int'(val[4*i +: 4]);
      end
      if (ok && dv < mods[d]) mv[d] = dv;
      else err = 1'b1;
    end else if (e) begin
      if (u) begin
        c     = (mv[d] == mods[d] - 1);
        mv[d] = c ? 0 : mv[d] + 1;
      end else begin
        c     = (mv[d] == 0);
        mv[d] = c ? mods[d] - 1 : mv[d] - 1;
      end
    end
    push_exp(d, c, err, tag);
    @(posedge clk);
    #1;
    load[d] = 1'b0;
    en[d]   = 1'b0;
    check_front();
  endtask

  initial begin
    preset = 3'b111;
    en     = '0;
    up_dn  = '0;
    load   = '0;
    lv0    = '0;
    lv1    = '0;
    lv2    = '0;
    #12;
    for (int d = 0; d < 3; d++) begin
      push_exp(d, 1'b0, 1'b0, "reset");
      check_front();
    end
    preset = '0;

    // Mod 60, up through the wrap
    step(0, 1, 0, 1, 12'h058, "m60_load58");
    step(0, 0, 1, 1, 12'h000, "m60_up59");
    step(0, 0, 1, 1, 12'h000, "m60_wrap00");
    step(0, 0, 1, 1, 12'h000, "m60_up01");
    // Down through the wrap
    step(0, 0, 1, 0, 12'h000, "m60_dn00");
    step(0, 0, 1, 0, 12'h000, "m60_wrap59");
    step(0, 0, 1, 0, 12'h000, "m60_dn58");
    step(0, 0, 0, 0, 12'h000, "m60_hold");
    // Load validation
    step(0, 1, 0, 1, 12'h04A, "m60_rej4A");
    step(0, 1, 0, 1, 12'h060, "m60_rej60");
    step(0, 1, 1, 1, 12'h0A5, "m60_rejA5_en");
    step(0, 1, 0, 1, 12'h045, "m60_load45");
    // Direction flips take effect on the same edge
    step(0, 0, 1, 1, 12'h000, "m60_up46");
    step(0, 0, 1, 0, 12'h000, "m60_dn45");
    step(0, 0, 1, 1, 12'h000, "m60_up46b");
    // Async preset mid-count
    step(0, 1, 0, 1, 12'h036, "m60_load36");
    step(0, 0, 1, 1, 12'h000, "m60_up37");
    en[0]    = 1'b1;
    up_dn[0] = 1'b1;
    #2;
    preset[0] = 1'b1;
    mv[0]     = 12;
    push_exp(0, 1'b0, 1'b0, "m60_preset12");
    #1;
    check_front();
    #1;
    preset[0] = 1'b0;
    step(0, 0, 1, 1, 12'h000, "m60_after13");

    // Mod 1000, three digits
    step(1, 1, 0, 1, 12'h999, "m1000_load999");
    step(1, 0, 1, 1, 12'h000, "m1000_wrap000");
    step(1, 0, 1, 0, 12'h000, "m1000_wrap999");
    step(1, 0, 1, 0, 12'h000, "m1000_dn998");
    step(1, 1, 0, 1, 12'h1B0, "m1000_rej1B0");
    step(1, 1, 0, 1, 12'h109, "m1000_load109");
    step(1, 0, 1, 1, 12'h000, "m1000_up110");

    // Mod 24
    step(2, 1, 0, 1, 12'h023, "m24_load23");
    step(2, 0, 1, 1, 12'h000, "m24_wrap00");
    step(2, 1, 0, 1, 12'h005, "m24_load05");
    step(2, 1, 1, 1, 12'h010, "m24_load10_en");
    step(2, 1, 0, 1, 12'h024, "m24_rej24");
    step(2, 1, 0, 1, 12'h000, "m24_load00");
    step(2, 0, 1, 0, 12'h000, "m24_wrap23");
    step(2, 0, 1, 1, 12'h000, "m24_wrap00b");

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: observed %0d entries expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
